// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues D-cache requests for LW/SW/LL/SC, stalls the
// pipeline until dhit, tracks the LL/SC link under snoop invalidation, and handles HALT.
module mem_stage_ctrl #(
  parameter logic [5:0] LW_OP = 6'b100011,
  parameter logic [5:0] SW_OP = 6'b101011,
  parameter logic [5:0] LL_OP = 6'b110000,
  parameter logic [5:0] SC_OP = 6'b111000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store,
  input  logic        ex_RegW,
  input  logic        ex_halt,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        memwb_enable,
  output logic [31:0] memwb_dload,
  output logic [31:0] memwb_alu_out,
  output logic        memwb_RegW,
  output logic        memwb_halt,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED} state_e;

  state_e      state_q, state_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        wait_write_q, wait_write_d;

  logic is_lw, is_sw, is_ll, is_sc, sc_ok, is_read, is_write;
  logic ren, wen, stall, enable, halt_pulse, complete;
  logic [31:0] dload;

  assign is_lw    = (ex_opcode == LW_OP);
  assign is_sw    = (ex_opcode == SW_OP);
  assign is_ll    = (ex_opcode == LL_OP);
  assign is_sc    = (ex_opcode == SC_OP);
  assign sc_ok    = link_valid_q && (link_addr_q == ex_alu_out);
  assign is_read  = is_lw || is_ll;
  assign is_write = is_sw || (is_sc && sc_ok);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wait_write_d = wait_write_q;
    ren          = 1'b0;
    wen          = 1'b0;
    stall        = 1'b0;
    enable       = 1'b0;
    halt_pulse   = 1'b0;
    complete     = 1'b0;
    dload        = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        if (!ex_valid) begin
          enable = 1'b1;
        end else if (ex_halt) begin
          enable     = 1'b1;
          halt_pulse = 1'b1;
          state_d    = S_HALTED;
        end else if (is_read || is_write) begin
          ren = is_read;
          wen = is_write;
          if (dhit) begin
            complete = 1'b1;
          end else begin
            stall        = 1'b1;
            wait_write_d = is_write;
            state_d      = S_WAIT;
          end
        end else begin
          // Non-memory op or an SC that already failed its link check.
          enable = 1'b1;
        end
      end
      S_WAIT: begin
        // Direction is held from issue so a snoop mid-SC cannot retract the write.
        ren = !wait_write_q;
        wen = wait_write_q;
        if (dhit) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      S_HALTED: stall = 1'b1;
      default:  state_d = S_IDLE;
    endcase

    if (complete) begin
      enable = 1'b1;
      if (ren)        dload = dmemload;
      else if (is_sc) dload = 32'd1;
    end
  end

  // Link updates in priority order: later assignments override earlier ones.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (snoop_inv && (snoop_addr == link_addr_q)) link_valid_d = 1'b0;
    if (complete && is_sw && (ex_alu_out == link_addr_q)) link_valid_d = 1'b0;
    if (complete && is_sc) link_valid_d = 1'b0;
    if (complete && is_ll) begin
      link_valid_d = 1'b1;
      link_addr_d  = ex_alu_out;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= 32'd0;
      wait_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      wait_write_q <= wait_write_d;
    end
  end

  // NOTE: outputs are gated by nRST so a request drops the instant reset asserts,
  // not at the next edge.
  assign dmemREN       = nRST && ren;
  assign dmemWEN       = nRST && wen;
  assign dmemaddr      = ex_alu_out;
  assign dmemstore     = ex_store;
  assign mem_stall     = nRST && stall;
  assign memwb_enable  = nRST && enable;
  assign memwb_dload   = dload;
  assign memwb_alu_out = ex_alu_out;
  assign memwb_RegW    = nRST && enable && ex_valid && ex_RegW;
  assign memwb_halt    = nRST && halt_pulse;
  assign halted        = (state_q == S_HALTED);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed test-plan sequences plus random
// instruction streams compared against a transaction-level model of the stage.
module tb_mem_stage_ctrl;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LL  = 6'b110000;
  localparam logic [5:0] OP_SC  = 6'b111000;
  localparam logic [5:0] OP_NOP = 6'b000000;

  typedef enum int {K_BUB, K_NOP, K_LW, K_SW, K_LL, K_SC, K_HALT} kind_e;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_valid, ex_RegW, ex_halt, dhit, snoop_inv;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_alu_out, ex_store, dmemload, snoop_addr;
  logic        dmemREN, dmemWEN, mem_stall, memwb_enable, memwb_RegW, memwb_halt, halted;
  logic [31:0] dmemaddr, dmemstore, memwb_dload, memwb_alu_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the link register and whether the core has halted.
  bit          m_link_valid;
  logic [31:0] m_link_addr;
  bit          m_halted;

  logic [31:0] addr_pool [4];

  mem_stage_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
    .ex_store(ex_store), .ex_RegW(ex_RegW), .ex_halt(ex_halt),
    .dhit(dhit), .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .memwb_enable(memwb_enable), .memwb_dload(memwb_dload),
    .memwb_alu_out(memwb_alu_out), .memwb_RegW(memwb_RegW), .memwb_halt(memwb_halt),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction held in EX/MEM for lat+1 cycles when it reaches the cache,
  // else one cycle. snoop_cyc selects the cycle (if any) carrying an invalidation.
  task automatic do_instr(input kind_e k, input logic [31:0] addr, input int lat_in,
                          input int snoop_cyc, input logic [31:0] snoop_a);
    bit rd, wr, req, sc_ok, regw, exp_en, exp_stall, exp_mh, done;
    int lat;
    logic [31:0] st, exp_dload;
    st    = $urandom;
    regw  = (k == K_HALT) ? 1'b0 : 1'($urandom_range(0, 1));
    sc_ok = m_link_valid && (m_link_addr == addr);
    rd    = (k == K_LW) || (k == K_LL);
    wr    = (k == K_SW) || ((k == K_SC) && sc_ok);
    req   = (rd || wr) && !m_halted;
    lat   = req ? lat_in : 0;
    for (int c = 0; c <= lat; c++) begin
      @(posedge CLK);
      #1;
      ex_valid   = (k != K_BUB);
      ex_halt    = (k == K_HALT);
      ex_RegW    = regw;
      ex_alu_out = addr;
      ex_store   = st;
      case (k)
        K_LW:    ex_opcode = OP_LW;
        K_SW:    ex_opcode = OP_SW;
        K_LL:    ex_opcode = OP_LL;
        K_SC:    ex_opcode = OP_SC;
        default: ex_opcode = OP_NOP;
      endcase
      dhit       = req && (c == lat);
      dmemload   = $urandom;
      snoop_inv  = (c == snoop_cyc);
      snoop_addr = snoop_a;
      #3;
      exp_dload = 32'd0;
      exp_mh    = 1'b0;
      if (m_halted) begin
        exp_en = 0; exp_stall = 1;
      end else if (req) begin
        exp_en    = (c == lat);
        exp_stall = (c < lat);
        if (rd) exp_dload = dmemload;
        else if (k == K_SC) exp_dload = 32'd1;
      end else begin
        exp_en = 1; exp_stall = 0; exp_mh = (k == K_HALT);
      end
      check("ren",    dmemREN,    req && rd);
      check("wen",    dmemWEN,    req && wr);
      check("stall",  mem_stall,  exp_stall);
      check("enable", memwb_enable, exp_en);
      check("regw",   memwb_RegW, exp_en && (k != K_BUB) && regw);
      check("mwhalt", memwb_halt, exp_mh);
      check("halted", halted,     m_halted);
      if (exp_en) begin
        check("dload",  memwb_dload,   exp_dload);
        check("aluout", memwb_alu_out, addr);
      end
      if (req) begin
        check("addr",  dmemaddr,  addr);
        check("store", dmemstore, st);
      end
      // Model of the clock edge that ends this cycle.
      done = req && (c == lat);
      if (snoop_inv && (snoop_a == m_link_addr)) m_link_valid = 0;
      if (done && (k == K_SW) && (addr == m_link_addr)) m_link_valid = 0;
      if (done && (k == K_SC)) m_link_valid = 0;
      if (done && (k == K_LL)) begin
        m_link_valid = 1;
        m_link_addr  = addr;
      end
      if ((k == K_HALT) && !m_halted) m_halted = 1;
    end
  endtask

  initial begin
    addr_pool[0] = 32'h100; addr_pool[1] = 32'h200;
    addr_pool[2] = 32'h204; addr_pool[3] = 32'h300;
    m_link_valid = 0; m_link_addr = 32'd0; m_halted = 0;

    // Reset with a valid LW presented: nothing may be requested or captured.
    nRST = 0; ex_valid = 1; ex_opcode = OP_LW; ex_alu_out = 32'h100; ex_store = 0;
    ex_RegW = 1; ex_halt = 0; dhit = 0; dmemload = 0; snoop_inv = 0; snoop_addr = 0;
    #12;
    check("rst_ren",    dmemREN, 1'b0);
    check("rst_enable", memwb_enable, 1'b0);
    check("rst_halted", halted, 1'b0);
    ex_valid = 0;
    #1 nRST = 1;

    // Test-plan sequences.
    do_instr(K_LW, 32'h100, 3, -1, 0);
    do_instr(K_LL, 32'h200, 1, -1, 0);
    do_instr(K_SC, 32'h200, 2, -1, 0);
    do_instr(K_SC, 32'h200, 0, -1, 0);
    do_instr(K_LL, 32'h200, 0, -1, 0);
    do_instr(K_NOP, 32'h0,  0,  0, 32'h200);
    do_instr(K_SC, 32'h200, 1, -1, 0);
    do_instr(K_LL, 32'h200, 0, -1, 0);
    do_instr(K_NOP, 32'h0,  0,  0, 32'h204);
    do_instr(K_SC, 32'h200, 1, -1, 0);
    do_instr(K_LL, 32'h200, 0,  0, 32'h200);
    do_instr(K_SC, 32'h200, 0, -1, 0);
    do_instr(K_LL, 32'h204, 2, -1, 0);
    do_instr(K_SW, 32'h204, 1, -1, 0);
    do_instr(K_SC, 32'h204, 0, -1, 0);

    // Random instruction stream.
    for (int i = 0; i < 400; i++) begin
      kind_e k;
      int lat, sc;
      k   = kind_e'($urandom_range(0, 5));
      lat = $urandom_range(0, 3);
      sc  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lat) : -1;
      do_instr(k, addr_pool[$urandom_range(0, 3)], lat, sc, addr_pool[$urandom_range(0, 3)]);
    end

    // Reset in the middle of a waiting SW after a valid link has been formed.
    do_instr(K_LL, 32'h300, 0, -1, 0);
    @(posedge CLK); #1;
    ex_valid = 1; ex_opcode = OP_SW; ex_alu_out = 32'h100; ex_halt = 0;
    dhit = 0; snoop_inv = 0;
    @(posedge CLK); #1;
    check("sw_wait_wen", dmemWEN, 1'b1);
    check("sw_wait_stall", mem_stall, 1'b1);
    nRST = 0;
    #1;
    check("rstw_ren", dmemREN, 1'b0);
    check("rstw_wen", dmemWEN, 1'b0);
    check("rstw_enable", memwb_enable, 1'b0);
    m_link_valid = 0; m_link_addr = 32'd0;
    ex_valid = 0;
    #1 nRST = 1;
    do_instr(K_LW, 32'h100, 0, -1, 0);
    do_instr(K_SC, 32'h300, 0, -1, 0);

    // HALT, then later valid loads must stay blocked.
    do_instr(K_HALT, 32'h0, 0, -1, 0);
    do_instr(K_LW, 32'h100, 2, -1, 0);
    do_instr(K_LW, 32'h200, 0,  0, 32'h200);
    do_instr(K_SW, 32'h204, 1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
